// File: rtl/vga_ctrl_param.sv
// Parametrised VGA timing generator with framebuffer request port,
// read-latency alignment pipeline and built-in test patterns.
module vga_ctrl_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 4,
    parameter int RD_LAT   = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                   Xclk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode_i,
    input  logic [3*COLOR_W-1:0]   pix_data_i,
    output logic                   pix_req_o,
    output logic [10:0]            pix_x_o,
    output logic [10:0]            pix_y_o,
    output logic                   frame_start_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   de_o,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [COLOR_W-1:0] FULL = '1;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BLACK = 2'd3
    } mode_t;

    logic [10:0] hc;
    logic [10:0] vc;
    mode_t       mode_q;

    logic active;
    logic hs_raw;
    logic vs_raw;
    logic at_origin;

    assign active    = (hc < H_ACT) && (vc < V_ACT);
    assign hs_raw    = (hc >= HS_BEG) && (hc < HS_END);
    assign vs_raw    = (vc >= VS_BEG) && (vc < VS_END);
    assign at_origin = (hc == 11'd0) && (vc == 11'd0);

    // Request side is gated by rst because the counters sit at (0,0).
    assign pix_req_o     = en && active && !rst;
    assign frame_start_o = en && at_origin && !rst;
    assign pix_x_o       = hc;
    assign pix_y_o       = vc;

    always_ff @(posedge Xclk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (!en) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
        end else begin
            hc <= hc + 11'd1;
        end
    end

    always_ff @(posedge Xclk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_FB;
        end else if (en && at_origin) begin
            mode_q <= mode_t'(mode_i);
        end
    end

    logic [RD_LAT-1:0] act_sr;
    logic [RD_LAT-1:0] hs_sr;
    logic [RD_LAT-1:0] vs_sr;
    logic [RD_LAT-1:0] y5_sr;
    logic [10:0]       x_sr [RD_LAT];

    // Only bit 5 of the row feeds the checker, so only it is delayed.
    always_ff @(posedge Xclk or posedge rst) begin
        if (rst) begin
            act_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
            y5_sr  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                x_sr[i] <= '0;
            end
        end else begin
            act_sr[0] <= en && active;
            hs_sr[0]  <= en && hs_raw;
            vs_sr[0]  <= en && vs_raw;
            y5_sr[0]  <= vc[5];
            x_sr[0]   <= hc;
            for (int i = 1; i < RD_LAT; i++) begin
                act_sr[i] <= act_sr[i-1];
                hs_sr[i]  <= hs_sr[i-1];
                vs_sr[i]  <= vs_sr[i-1];
                y5_sr[i]  <= y5_sr[i-1];
                x_sr[i]   <= x_sr[i-1];
            end
        end
    end

    logic        act_d;
    logic        hs_d;
    logic        vs_d;
    logic        y5_d;
    logic [10:0] x_d;

    assign act_d = act_sr[RD_LAT-1];
    assign hs_d  = hs_sr[RD_LAT-1];
    assign vs_d  = vs_sr[RD_LAT-1];
    assign y5_d  = y5_sr[RD_LAT-1];
    assign x_d   = x_sr[RD_LAT-1];

    logic [2:0]         bar;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    // Bar index (x*8)/H_ACTIVE built from seven threshold compares.
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if ({x_d, 3'b000} >= 14'(k * H_ACTIVE)) begin
                bar = 3'(k);
            end
        end
    end

    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (act_d) begin
            unique case (mode_q)
                MODE_FB: begin
                    {pix_r, pix_g, pix_b} = pix_data_i;
                end
                MODE_BARS: begin
                    pix_r = bar[1] ? '0 : FULL;
                    pix_g = bar[2] ? '0 : FULL;
                    pix_b = bar[0] ? '0 : FULL;
                end
                MODE_CHECK: begin
                    if (x_d[5] ^ y5_d) begin
                        pix_r = FULL;
                        pix_g = FULL;
                        pix_b = FULL;
                    end
                end
                MODE_BLACK: begin
                    pix_r = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Xclk or posedge rst) begin
        if (rst) begin
            de_o    <= 1'b0;
            hsync_o <= ~HS_POL;
            vsync_o <= ~VS_POL;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else begin
            de_o    <= act_d;
            hsync_o <= hs_d ? HS_POL : ~HS_POL;
            vsync_o <= vs_d ? VS_POL : ~VS_POL;
            red_o   <= pix_r;
            green_o <= pix_g;
            blue_o  <= pix_b;
        end
    end

endmodule
